cla_share_arb: RTL and testbench
================================

CLA_SHARE_ARB -- requirements
Module: cla_share_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the 64-bit KPG carry-lookahead adder.
REQ-002 Parameter LOCK_TMO, default 16, SHALL set the maximum idle cycles a chained lock is held.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid  input  NREQ  requester i has an operation pending.
REQ-006 req_ready  output  NREQ  one-hot; the operation from requester i is accepted this cycle.
REQ-007 req_a  input  NREQ*64  operand A, slice i = bits [64i+63:64i].
REQ-008 req_b  input  NREQ*64  operand B, same slicing.
REQ-009 req_cin  input  NREQ  carry-in for an unchained or first beat.
REQ-010 req_last  input  NREQ  1 = final beat; 0 = chain the next beat of the same requester.
REQ-011 rsp_valid  output  1  the result registers hold a valid result.
REQ-012 rsp_ready  input  1  the consumer accepts the result.
REQ-013 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-014 rsp_sum  output  64  result sum.
REQ-015 rsp_cout  output  1  result carry-out.
REQ-016 lock_err  output  1  one-cycle pulse when a chain lock times out.

Function
REQ-017 The block SHALL own exactly one 64-bit adder computing {cout,sum} = a + b + cin, driven only from internal operand registers.
REQ-018 The FSM SHALL use states IDLE, CALC, RESP and LOCK.
REQ-019 In IDLE, the arbiter SHALL grant the first valid requester at or after rr_ptr, wrapping modulo NREQ.
REQ-020 On grant, req_ready[g] SHALL be 1 for that cycle only; a_r, b_r, cin_r, id_r and last_r SHALL latch, and the FSM SHALL go to CALC.
REQ-021 In CALC, the adder result SHALL register into rsp_sum and rsp_cout, and the FSM SHALL go to RESP.
REQ-022 In RESP, rsp_valid SHALL be 1, and rsp_sum, rsp_cout and rsp_id SHALL hold stable until rsp_ready=1.
REQ-023 Latency: for acceptance at cycle N, rsp_valid SHALL first assert at N+2; peak throughput is one operation per 3 cycles.
REQ-024 When RESP completes with last_r=1, the FSM SHALL go to IDLE and set rr_ptr = id_r+1 mod NREQ.
REQ-025 When RESP completes with last_r=0, the FSM SHALL go to LOCK, save carry_r = rsp_cout, and clear the timeout counter.
REQ-026 In LOCK, only requester id_r SHALL be grantable; its beat SHALL use cin = carry_r, and req_cin SHALL be ignored.
REQ-027 In LOCK, each cycle without req_valid[id_r] SHALL increment the timeout counter.
REQ-028 On reaching LOCK_TMO, the block SHALL pulse lock_err, go to IDLE, and advance rr_ptr past id_r.
REQ-029 req_ready SHALL be all-zero in CALC and RESP, and all-zero in LOCK except bit id_r.
REQ-030 A requester that drops req_valid while not granted SHALL lose nothing; no request state is stored before acceptance.
REQ-031 If rsp_ready is asserted while rsp_valid=0, it SHALL be ignored.
REQ-032 With NREQ not a power of two, the pointer SHALL wrap from NREQ-1 to 0.

Reset
REQ-033 While rst_n=0 at a clock edge, the FSM SHALL enter IDLE.
REQ-034 Reset SHALL set rr_ptr=0, the timeout counter to 0 and carry_r=0.
REQ-035 Reset SHALL drive rsp_valid=0, req_ready=0, rsp_sum=0, rsp_cout=0, rsp_id=0 and lock_err=0.
REQ-036 Reset mid-operation, including during LOCK, SHALL discard the in-flight result and chain with no response.

Verification
REQ-037 Single op: req0 with a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, last=1 -> req_ready[0] at N; at N+2 rsp_valid=1, sum=0, cout=1, id=0.
REQ-038 Fairness: all four valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-039 128-bit chain: req2 beat1 a=0xFFFF_FFFF_FFFF_FFFF, b=1, last=0; beat2 a=0, b=0, last=1 while req1 is also valid -> beat1 sum=0, cout=1; beat2 sum=1 with req1 blocked until beat2 completes, then req1 is granted.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready all-zero, and the next grant occurs 1 cycle after rsp_ready=1.
REQ-041 Lock timeout: last=0 beat, then the requester idles -> lock_err pulses LOCK_TMO cycles after LOCK entry, and another valid requester is granted the next cycle.
REQ-042 Reset in RESP with rsp_valid=1 -> rsp_valid=0 on the next edge, rr_ptr=0, and the first subsequent grant goes to the lowest valid index.

Source files
------------

// File: rtl/cla_share_arb.sv
// rtl/cla_share_arb.sv - round-robin shared 64-bit KPG carry-lookahead adder with chained-carry lock
module cla_share_arb #(
    parameter int NREQ     = 4,
    parameter int LOCK_TMO = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*64-1:0]        req_a,
    input  logic [NREQ*64-1:0]        req_b,
    input  logic [NREQ-1:0]           req_cin,
    input  logic [NREQ-1:0]           req_last,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [63:0]               rsp_sum,
    output logic                      rsp_cout,
    output logic                      lock_err
);
    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(LOCK_TMO + 1);

    typedef enum logic [1:0] {IDLE, CALC, RESP, LOCK} state_t;

    // Bit 0 of the prefix vectors holds cin as a pure generate; bits 1..64 are operand bits 0..63.
    function automatic logic [64:0] kpg_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin);
        logic [64:0] g;
        logic [64:0] p;
        logic [64:0] mask;
        g = {a & b, cin};
        p = {a ^ b, 1'b0};
        for (int l = 0; l < 7; l++) begin
            mask = (65'd1 << (1 << l)) - 65'd1;
            g    = g | (p & (g << (1 << l)));
            p    = p & ((p << (1 << l)) | mask);
        end
        return {g[64], a ^ b ^ g[63:0]};
    endfunction

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [63:0]     a_q, a_d, b_q, b_d;
    logic            cin_q, cin_d, last_q, last_d, carry_q, carry_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_cout_q, rsp_cout_d;
    logic [63:0]     rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            lock_err_q, lock_err_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  sel_id, beat_id;
    logic            sel_found, take;
    logic [64:0]     sum_full;

    assign sum_full = kpg_add(a_q, b_q, cin_q);

    // Descending scan so the requester closest to rr_ptr wins.
    always_comb begin
        sel_id    = rr_ptr_q;
        sel_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr_q, k)]) begin
                sel_found = 1'b1;
                sel_id    = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        last_d      = last_q;
        id_d        = id_q;
        carry_d     = carry_q;
        tmo_d       = tmo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        lock_err_d  = 1'b0;
        gnt         = '0;
        beat_id     = sel_id;
        take        = 1'b0;

        case (state_q)
            IDLE: take = sel_found;
            CALC: begin
                {rsp_cout_d, rsp_sum_d} = sum_full;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (last_q) begin
                        state_d  = IDLE;
                        rr_ptr_d = wrap_add(id_q, 1);
                    end else begin
                        state_d = LOCK;
                        carry_d = rsp_cout_q;
                        tmo_d   = '0;
                    end
                end
            end
            LOCK: begin
                beat_id = id_q;
                take    = req_valid[id_q];
                if (!req_valid[id_q]) begin
                    if (tmo_q == TW'(LOCK_TMO - 1)) begin
                        lock_err_d = 1'b1;
                        state_d    = IDLE;
                        rr_ptr_d   = wrap_add(id_q, 1);
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A chained beat takes its carry from the previous beat, never from req_cin.
        if (take) begin
            gnt[beat_id] = 1'b1;
            a_d          = req_a[int'(beat_id)*64 +: 64];
            b_d          = req_b[int'(beat_id)*64 +: 64];
            cin_d        = (state_q == LOCK) ? carry_q : req_cin[beat_id];
            last_d       = req_last[beat_id];
            id_d         = beat_id;
            state_d      = CALC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            last_q      <= 1'b0;
            id_q        <= '0;
            carry_q     <= 1'b0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            last_q      <= last_d;
            id_q        <= id_d;
            carry_q     <= carry_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            lock_err_q  <= lock_err_d;
        end
    end

    assign req_ready = rst_n ? gnt : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign lock_err  = lock_err_q;

endmodule

// File: tb/tb_cla_share_arb.sv
// tb/tb_cla_share_arb.sv - self-checking bench for cla_share_arb
module tb_cla_share_arb;
    localparam int NREQ     = 4;
    localparam int LOCK_TMO = 16;
    localparam int IDW      = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid, req_ready, req_cin, req_last;
    logic [NREQ*64-1:0]   req_a, req_b;
    logic                 rsp_valid, rsp_ready, rsp_cout, lock_err;
    logic [IDW-1:0]       rsp_id;
    logic [63:0]          rsp_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_share_arb #(.NREQ(NREQ), .LOCK_TMO(LOCK_TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .lock_err(lock_err)
    );

    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + 65'(c);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_cin = '0; req_last = '0; req_a = '0; req_b = '0;
    endtask

    task automatic drive(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic last);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        req_cin[i]        = cin;
        req_last[i]       = last;
        req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rsp_ready = 1'b0; idle_inputs();
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 4'b1011;
        tick(); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (rsp_sum !== 64'd0) begin errors++; $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum); end
        checks++; if ({rsp_cout, rsp_id, lock_err} !== 4'b0) begin errors++; $display("FAIL reset_misc: got cout=%b id=%0d lock_err=%b want 0", rsp_cout, rsp_id, lock_err); end
        idle_inputs();
    endtask

    task automatic test_single_op();
        do_reset(); rsp_ready = 1'b1;
        drive(0, '1, 64'd1, 1'b0, 1'b1); #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        tick(); idle_inputs(); #1;
        checks++; if ({rsp_valid, req_ready} !== 5'b0) begin errors++; $display("FAIL single_calc: got valid=%b ready=%b want 0/0000", rsp_valid, req_ready); end
        tick(); #1;
        checks++; if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 2'd0, 1'b1, 64'd0})
            begin errors++; $display("FAIL single_rsp: got v=%b id=%0d cout=%b sum=%h want 1/0/1/0", rsp_valid, rsp_id, rsp_cout, rsp_sum); end
        tick(); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_done: got %b want 0", rsp_valid); end
    endtask

    task automatic test_fairness();
        logic [63:0] fa[NREQ];
        logic [63:0] fb[NREQ];
        logic        fc[NREQ];
        logic [NREQ-1:0] exp_rdy;
        logic [64:0] exp;
        int g;
        do_reset(); rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            fa[i] = rnd64(); fb[i] = rnd64(); fc[i] = 1'($urandom_range(0, 1));
            drive(i, fa[i], fb[i], fc[i], 1'b1);
        end
        for (int c = 0; c < 15; c++) begin
            #1;
            exp_rdy = (c % 3 == 0) ? 4'(1 << ((c / 3) % NREQ)) : 4'b0;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_grant c=%0d: got %b want %b", c, req_ready, exp_rdy); end
            if (c % 3 == 2) begin
                g = (c / 3) % NREQ;
                exp = ref_add(fa[g], fb[g], fc[g]);
                checks++; if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, IDW'(g), exp})
                    begin errors++; $display("FAIL fair_rsp c=%0d: got v=%b id=%0d cout=%b sum=%h want id=%0d cout=%b sum=%h", c, rsp_valid, rsp_id, rsp_cout, rsp_sum, g, exp[64], exp[63:0]); end
            end
            tick();
        end
    endtask

    task automatic test_chain();
        do_reset(); rsp_ready = 1'b1;
        drive(2, '1, 64'd1, 1'b0, 1'b0); #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL chain_beat1_grant: got %b want 0100", req_ready); end
        tick();
        drive(2, 64'd0, 64'd0, 1'b0, 1'b1);
        drive(1, rnd64(), rnd64(), 1'b0, 1'b1); #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL chain_calc_ready: got %b want 0000", req_ready); end
        tick(); #1;
        checks++; if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 2'd2, 1'b1, 64'd0})
            begin errors++; $display("FAIL chain_beat1_rsp: got v=%b id=%0d cout=%b sum=%h want 1/2/1/0", rsp_valid, rsp_id, rsp_cout, rsp_sum); end
        tick(); #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL chain_lock_grant: got %b want 0100", req_ready); end
        tick(); req_valid[2] = 1'b0; #1;
        tick(); #1;
        checks++; if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 2'd2, 1'b0, 64'd1})
            begin errors++; $display("FAIL chain_beat2_rsp: got v=%b id=%0d cout=%b sum=%h want 1/2/0/1", rsp_valid, rsp_id, rsp_cout, rsp_sum); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL chain_req1_blocked: got %b want 0000", req_ready); end
        tick(); #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL chain_req1_after: got %b want 0010", req_ready); end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b;
        logic        c;
        logic [64:0] exp;
        do_reset(); rsp_ready = 1'b0;
        a = rnd64(); b = rnd64(); c = 1'($urandom_range(0, 1)); exp = ref_add(a, b, c);
        drive(3, a, b, c, 1'b1); #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
        tick(); idle_inputs(); drive(0, rnd64(), rnd64(), 1'b0, 1'b1); #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_calc: got %b want 0000", req_ready); end
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 2'd3, exp})
                begin errors++; $display("FAIL bp_hold k=%0d: got v=%b id=%0d cout=%b sum=%h want 1/3/%b/%h", k, rsp_valid, rsp_id, rsp_cout, rsp_sum, exp[64], exp[63:0]); end
            checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_ready_low k=%0d: got %b want 0000", k, req_ready); end
            tick();
        end
        rsp_ready = 1'b1; #1;
        checks++; if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 2'd3, exp})
            begin errors++; $display("FAIL bp_release: got v=%b id=%0d sum=%h want 1/3/%h", rsp_valid, rsp_id, rsp_sum, exp[63:0]); end
        tick(); rsp_ready = 1'b0; #1;
        checks++; if ({rsp_valid, req_ready} !== 5'b00001) begin errors++; $display("FAIL bp_next_grant: got v=%b ready=%b want 0/0001", rsp_valid, req_ready); end
    endtask

    task automatic test_lock_timeout();
        do_reset(); rsp_ready = 1'b1;
        drive(1, rnd64(), rnd64(), 1'b0, 1'b0); #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_grant: got %b want 0010", req_ready); end
        tick(); idle_inputs(); drive(3, rnd64(), rnd64(), 1'b0, 1'b1);
        tick(); #1;
        checks++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL lock_beat_rsp: got v=%b id=%0d want 1/1", rsp_valid, rsp_id); end
        tick();
        for (int k = 0; k < LOCK_TMO; k++) begin
            #1;
            checks++; if ({lock_err, req_ready} !== 5'b0) begin errors++; $display("FAIL lock_hold k=%0d: got err=%b ready=%b want 0/0000", k, lock_err, req_ready); end
            tick();
        end
        #1;
        checks++; if (lock_err !== 1'b1) begin errors++; $display("FAIL lock_err_pulse: got %b want 1", lock_err); end
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_next_grant: got %b want 1000", req_ready); end
        tick(); idle_inputs(); #1;
        checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL lock_err_once: got %b want 0", lock_err); end
    endtask

    task automatic test_reset_in_resp();
        do_reset(); rsp_ready = 1'b1;
        drive(0, rnd64(), rnd64(), 1'b0, 1'b1); #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first: got %b want 0001", req_ready); end
        tick(); idle_inputs(); tick(); tick();
        rsp_ready = 1'b0; drive(2, rnd64(), rnd64(), 1'b1, 1'b1); #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rr_second: got %b want 0100", req_ready); end
        tick(); idle_inputs(); tick(); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_resp: got %b want 1", rsp_valid); end
        rst_n = 1'b0; tick(); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_reset_flush: got %b want 0", rsp_valid); end
        rst_n = 1'b1;
        drive(0, rnd64(), rnd64(), 1'b0, 1'b1);
        drive(3, rnd64(), rnd64(), 1'b0, 1'b1); #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_ptr_reset: got %b want 0001", req_ready); end
    endtask

    // Model: one op in flight at a time, round-robin from the owner after the last one, chains pin the owner.
    task automatic test_random();
        bit          pend[NREQ];
        logic [63:0] ma[NREQ];
        logic [63:0] mb[NREQ];
        logic        mc[NREQ];
        logic        ml[NREQ];
        int          ptr = 0;
        int          owner = 0;
        int          acc_cyc = 0;
        int          nrsp = 0;
        bit          busy = 0;
        bit          locked = 0;
        logic        carry = 1'b0;
        logic        exp_last = 1'b0;
        logic [64:0] exp_res = '0;
        logic [NREQ-1:0] exp_rdy;
        bit          exp_rv;
        int          idx;
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ((locked && !busy && i == owner) || $urandom_range(0, 9) < 4) begin
                        ma[i] = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : rnd64();
                        mb[i] = ($urandom_range(0, 3) == 0) ? 64'd1 : rnd64();
                        mc[i] = 1'($urandom_range(0, 1));
                        ml[i] = ($urandom_range(0, 3) != 0);
                        pend[i] = 1;
                    end
                end else if (!(locked && i == owner) && $urandom_range(0, 19) == 0) begin
                    pend[i] = 0;
                end
                req_valid[i] = pend[i];
                req_a[64*i +: 64] = ma[i];
                req_b[64*i +: 64] = mb[i];
                req_cin[i] = mc[i];
                req_last[i] = ml[i];
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_rdy = '0;
            if (!busy) begin
                if (locked) begin
                    if (pend[owner]) exp_rdy[owner] = 1'b1;
                end else begin
                    for (int k = 0; k < NREQ; k++) begin
                        idx = (ptr + k) % NREQ;
                        if (pend[idx]) begin exp_rdy[idx] = 1'b1; break; end
                    end
                end
            end
            exp_rv = busy && (cyc >= acc_cyc + 2);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d: got %b want %b", cyc, req_ready, exp_rdy); end
            checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_rsp_valid cyc=%0d: got %b want %b", cyc, rsp_valid, exp_rv); end
            if (exp_rv) begin
                checks++; if ({rsp_id, rsp_cout, rsp_sum} !== {IDW'(owner), exp_res})
                    begin errors++; $display("FAIL rnd_rsp_data cyc=%0d: got id=%0d cout=%b sum=%h want id=%0d cout=%b sum=%h", cyc, rsp_id, rsp_cout, rsp_sum, owner, exp_res[64], exp_res[63:0]); end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rdy[i]) begin
                    exp_res  = ref_add(ma[i], mb[i], locked ? carry : mc[i]);
                    exp_last = ml[i];
                    owner    = i;
                    acc_cyc  = cyc;
                    busy     = 1;
                    pend[i]  = 0;
                end
            end
            if (exp_rv && rsp_ready) begin
                busy = 0;
                nrsp++;
                if (exp_last) begin
                    locked = 0;
                    ptr = (owner + 1) % NREQ;
                end else begin
                    locked = 1;
                    carry = exp_res[64];
                end
            end
            tick();
        end
        checks++; if (nrsp < 50) begin errors++; $display("FAIL rnd_progress: got %0d responses want at least 50", nrsp); end
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0; idle_inputs();
        test_reset();
        test_single_op();
        test_fairness();
        test_chain();
        test_backpressure();
        test_lock_timeout();
        test_reset_in_resp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
